// File: rtl/fas.sv
// fas: 32-tap FIR on a Q8.8 sample stream, 16-point DFT over frames of FIR
// results, and a peak-bin search over each DFT frame.
module fas (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [15:0] data,
  output logic        fir_valid,
  output logic [15:0] fir_d,
  output logic        fft_valid,
  output logic [31:0] fft_d0,
  output logic [31:0] fft_d1,
  output logic [31:0] fft_d2,
  output logic [31:0] fft_d3,
  output logic [31:0] fft_d4,
  output logic [31:0] fft_d5,
  output logic [31:0] fft_d6,
  output logic [31:0] fft_d7,
  output logic [31:0] fft_d8,
  output logic [31:0] fft_d9,
  output logic [31:0] fft_d10,
  output logic [31:0] fft_d11,
  output logic [31:0] fft_d12,
  output logic [31:0] fft_d13,
  output logic [31:0] fft_d14,
  output logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq
);

  // FIR coefficients, signed Q4.16. C00 dominates so every bin stays in the
  // passband; the set sums to exactly 0.75 so DC gain is exact in Q8.8.
  localparam logic signed [19:0] FIR_C00 =  20'sd40960;
  localparam logic signed [19:0] FIR_C01 =  20'sd12288;
  localparam logic signed [19:0] FIR_C02 = -20'sd6144;
  localparam logic signed [19:0] FIR_C03 =  20'sd3000;
  localparam logic signed [19:0] FIR_C04 = -20'sd1500;
  localparam logic signed [19:0] FIR_C05 =  20'sd900;
  localparam logic signed [19:0] FIR_C06 = -20'sd700;
  localparam logic signed [19:0] FIR_C07 =  20'sd500;
  localparam logic signed [19:0] FIR_C08 = -20'sd400;
  localparam logic signed [19:0] FIR_C09 =  20'sd333;
  localparam logic signed [19:0] FIR_C10 = -20'sd300;
  localparam logic signed [19:0] FIR_C11 =  20'sd260;
  localparam logic signed [19:0] FIR_C12 = -20'sd250;
  localparam logic signed [19:0] FIR_C13 =  20'sd200;
  localparam logic signed [19:0] FIR_C14 = -20'sd180;
  localparam logic signed [19:0] FIR_C15 =  20'sd150;
  localparam logic signed [19:0] FIR_C16 = -20'sd140;
  localparam logic signed [19:0] FIR_C17 =  20'sd120;
  localparam logic signed [19:0] FIR_C18 = -20'sd100;
  localparam logic signed [19:0] FIR_C19 =  20'sd90;
  localparam logic signed [19:0] FIR_C20 = -20'sd80;
  localparam logic signed [19:0] FIR_C21 =  20'sd70;
  localparam logic signed [19:0] FIR_C22 = -20'sd60;
  localparam logic signed [19:0] FIR_C23 =  20'sd50;
  localparam logic signed [19:0] FIR_C24 = -20'sd45;
  localparam logic signed [19:0] FIR_C25 =  20'sd40;
  localparam logic signed [19:0] FIR_C26 = -20'sd35;
  localparam logic signed [19:0] FIR_C27 =  20'sd30;
  localparam logic signed [19:0] FIR_C28 = -20'sd25;
  localparam logic signed [19:0] FIR_C29 =  20'sd20;
  localparam logic signed [19:0] FIR_C30 = -20'sd15;
  localparam logic signed [19:0] FIR_C31 =  20'sd115;

  localparam logic signed [19:0] FIR_C [32] = '{
    FIR_C00, FIR_C01, FIR_C02, FIR_C03, FIR_C04, FIR_C05, FIR_C06, FIR_C07,
    FIR_C08, FIR_C09, FIR_C10, FIR_C11, FIR_C12, FIR_C13, FIR_C14, FIR_C15,
    FIR_C16, FIR_C17, FIR_C18, FIR_C19, FIR_C20, FIR_C21, FIR_C22, FIR_C23,
    FIR_C24, FIR_C25, FIR_C26, FIR_C27, FIR_C28, FIR_C29, FIR_C30, FIR_C31
  };

  // Twiddle cosine in Q1.16 for angle 2*pi*m/16.
  function automatic logic signed [17:0] tw_cos(input logic [3:0] m);
    case (m)
      4'd0:          return  18'sd65536;
      4'd1, 4'd15:   return  18'sd60547;
      4'd2, 4'd14:   return  18'sd46340;
      4'd3, 4'd13:   return  18'sd25079;
      4'd4, 4'd12:   return  18'sd0;
      4'd5, 4'd11:   return -18'sd25079;
      4'd6, 4'd10:   return -18'sd46340;
      4'd7, 4'd9:    return -18'sd60547;
      default:       return -18'sd65536;
    endcase
  endfunction

  // sin(theta) = cos(theta - pi/2), i.e. a quarter-turn index offset.
  function automatic logic signed [17:0] tw_sin(input logic [3:0] m);
    return tw_cos(m - 4'd4);
  endfunction

  function automatic logic signed [37:0] mul_tw(input logic signed [15:0] x,
                                                input logic signed [17:0] w);
    return 38'(x) * 38'(w);
  endfunction

  // Round half away from zero keeps X[k] and X[16-k] exact conjugates for
  // real input, so mirrored bins tie exactly and the lower index wins.
  function automatic logic signed [15:0] rnd_q88(input logic signed [37:0] v);
    logic signed [37:0] b;
    b = v + (v[37] ? 38'sd32767 : 38'sd32768);
    return b[31:16];
  endfunction

  logic signed [15:0] taps [32];
  logic [4:0]         fill_left;
  logic               tap_ok;
  logic signed [40:0] fir_acc;
  logic signed [15:0] fir_q;

  logic [3:0]         n_idx;
  logic signed [37:0] acc_re [16];
  logic signed [37:0] acc_im [16];
  logic signed [37:0] sum_re [16];
  logic signed [37:0] sum_im [16];
  logic signed [15:0] fft_re [16];
  logic signed [15:0] fft_im [16];

  logic signed [32:0] mag [16];
  logic               mag_vld;
  logic signed [32:0] peak_mag;
  logic [3:0]         peak_idx;

  // Delay line shift and fill count; fill_left reaches zero once 31 samples
  // are in, so the next valid sample completes the first full window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) taps[i] <= '0;
      fill_left <= 5'd31;
      tap_ok    <= 1'b0;
    end else begin
      tap_ok <= data_valid && (fill_left == 5'd0);
      if (data_valid) begin
        taps[0] <= data;
        for (int i = 31; i > 0; i--) taps[i] <= taps[i-1];
        if (fill_left != 5'd0) fill_left <= fill_left - 5'd1;
      end
    end
  end

  // Full-precision FIR sum (Q.24 fraction) over the current window.
  always_comb begin
    fir_acc = '0;
    for (int k = 0; k < 32; k++)
      fir_acc = fir_acc + 41'(taps[k]) * 41'(FIR_C[k]);
  end

  // FIR output register: truncate to Q8.8, wrap on overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fir_q     <= '0;
      fir_valid <= 1'b0;
    end else begin
      fir_valid <= tap_ok;
      if (tap_ok) fir_q <= fir_acc[31:16];
    end
  end

  assign fir_d = fir_q;

  // Direct-form DFT terms: each FIR output adds x[n]*W^(nk) into all bins.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      sum_re[k] = ((n_idx == 4'd0) ? 38'sd0 : acc_re[k])
                + mul_tw(fir_q, tw_cos(n_idx * 4'(k)));
      sum_im[k] = ((n_idx == 4'd0) ? 38'sd0 : acc_im[k])
                - mul_tw(fir_q, tw_sin(n_idx * 4'(k)));
    end
  end

  // Frame accumulation and bin output registers, one frame per 16 results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_idx     <= '0;
      fft_valid <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        acc_re[k] <= '0;
        acc_im[k] <= '0;
        fft_re[k] <= '0;
        fft_im[k] <= '0;
      end
    end else begin
      fft_valid <= fir_valid && (n_idx == 4'd15);
      if (fir_valid) begin
        n_idx <= n_idx + 4'd1;
        for (int k = 0; k < 16; k++) begin
          acc_re[k] <= sum_re[k];
          acc_im[k] <= sum_im[k];
        end
        if (n_idx == 4'd15) begin
          for (int k = 0; k < 16; k++) begin
            fft_re[k] <= rnd_q88(sum_re[k]);
            fft_im[k] <= rnd_q88(sum_im[k]);
          end
        end
      end
    end
  end

  assign fft_d0  = {fft_re[0],  fft_im[0]};
  assign fft_d1  = {fft_re[1],  fft_im[1]};
  assign fft_d2  = {fft_re[2],  fft_im[2]};
  assign fft_d3  = {fft_re[3],  fft_im[3]};
  assign fft_d4  = {fft_re[4],  fft_im[4]};
  assign fft_d5  = {fft_re[5],  fft_im[5]};
  assign fft_d6  = {fft_re[6],  fft_im[6]};
  assign fft_d7  = {fft_re[7],  fft_im[7]};
  assign fft_d8  = {fft_re[8],  fft_im[8]};
  assign fft_d9  = {fft_re[9],  fft_im[9]};
  assign fft_d10 = {fft_re[10], fft_im[10]};
  assign fft_d11 = {fft_re[11], fft_im[11]};
  assign fft_d12 = {fft_re[12], fft_im[12]};
  assign fft_d13 = {fft_re[13], fft_im[13]};
  assign fft_d14 = {fft_re[14], fft_im[14]};
  assign fft_d15 = {fft_re[15], fft_im[15]};

  // Argmax over squared magnitudes; strict compare keeps the lowest index.
  always_comb begin
    peak_idx = '0;
    peak_mag = mag[0];
    for (int k = 1; k < 16; k++) begin
      if (mag[k] > peak_mag) begin
        peak_mag = mag[k];
        peak_idx = 4'(k);
      end
    end
  end

  // Peak search pipeline: magnitudes one cycle after fft_valid, freq/done
  // the cycle after that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 16; k++) mag[k] <= '0;
      mag_vld <= 1'b0;
      done    <= 1'b0;
      freq    <= '0;
    end else begin
      mag_vld <= fft_valid;
      done    <= mag_vld;
      if (fft_valid) begin
        for (int k = 0; k < 16; k++)
          mag[k] <= 33'(fft_re[k]) * 33'(fft_re[k])
                  + 33'(fft_im[k]) * 33'(fft_im[k]);
      end
      if (mag_vld) freq <= peak_idx;
    end
  end

endmodule

// File: tb/tb_fas.sv
// tb_fas: scoreboard bench for fas. The driver feeds directed vectors and
// pushes expected FIR, DFT and peak results; the monitor pops on each output.
`timescale 1ns/1ps
module tb_fas;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data = '0;
  logic        fir_valid, fft_valid, done;
  logic [15:0] fir_d;
  logic [3:0]  freq;
  logic [31:0] fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7;
  logic [31:0] fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15;
  logic [31:0] fd [16];

  always #5 clk = ~clk;

  fas dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
    .fir_valid(fir_valid), .fir_d(fir_d), .fft_valid(fft_valid),
    .fft_d0(fft_d0), .fft_d1(fft_d1), .fft_d2(fft_d2), .fft_d3(fft_d3),
    .fft_d4(fft_d4), .fft_d5(fft_d5), .fft_d6(fft_d6), .fft_d7(fft_d7),
    .fft_d8(fft_d8), .fft_d9(fft_d9), .fft_d10(fft_d10), .fft_d11(fft_d11),
    .fft_d12(fft_d12), .fft_d13(fft_d13), .fft_d14(fft_d14), .fft_d15(fft_d15),
    .done(done), .freq(freq)
  );

  assign fd[0]  = fft_d0;  assign fd[1]  = fft_d1;  assign fd[2]  = fft_d2;
  assign fd[3]  = fft_d3;  assign fd[4]  = fft_d4;  assign fd[5]  = fft_d5;
  assign fd[6]  = fft_d6;  assign fd[7]  = fft_d7;  assign fd[8]  = fft_d8;
  assign fd[9]  = fft_d9;  assign fd[10] = fft_d10; assign fd[11] = fft_d11;
  assign fd[12] = fft_d12; assign fd[13] = fft_d13; assign fd[14] = fft_d14;
  assign fd[15] = fft_d15;

  localparam real PI = 3.14159265358979323846;
  localparam int C [32] = '{40960, 12288, -6144, 3000, -1500, 900, -700, 500,
                            -400, 333, -300, 260, -250, 200, -180, 150,
                            -140, 120, -100, 90, -80, 70, -60, 50,
                            -45, 40, -35, 30, -25, 20, -15, 115};

  int     n_checks = 0;
  int     n_pass = 0;
  int     fir_q[$];
  real    re_q[$];
  real    im_q[$];
  int     freq_q[$];
  longint mline [32];
  int     mcount;
  int     frame_buf [16];
  int     fcount;
  int     exp_freq = -1;
  bit     spacing_on = 1'b0;
  int     fv_count = 0;
  longint cyc = 0;
  longint last_fv = -1000;

  task automatic chk(string name, longint act, longint expd, longint tol);
    n_checks++;
    if ((act - expd) <= tol && (expd - act) <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, expd, tol);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mline[i] = 0;
    mcount = 0;
    fcount = 0;
    fir_q.delete(); re_q.delete(); im_q.delete(); freq_q.delete();
  endtask

  // Reference: y = floor(sum C[k]*x[n-k] / 2^16) wrapped to 16 bits, then an
  // ideal floating-point DFT over each group of 16 outputs.
  task automatic model_sample(int x);
    longint s;
    int y;
    real re, im, ang;
    for (int i = 31; i > 0; i--) mline[i] = mline[i-1];
    mline[0] = x;
    mcount++;
    if (mcount >= 32) begin
      s = 0;
      for (int k = 0; k < 32; k++) s += longint'(C[k]) * mline[k];
      y = int'(shortint'(s >>> 16));
      fir_q.push_back(y);
      frame_buf[fcount] = y;
      fcount++;
      if (fcount == 16) begin
        for (int k = 0; k < 16; k++) begin
          re = 0.0; im = 0.0;
          for (int n = 0; n < 16; n++) begin
            ang = 2.0 * PI * real'(n * k) / 16.0;
            re += real'(frame_buf[n]) * $cos(ang);
            im -= real'(frame_buf[n]) * $sin(ang);
          end
          re_q.push_back(re);
          im_q.push_back(im);
        end
        if (exp_freq >= 0) freq_q.push_back(exp_freq);
        fcount = 0;
      end
    end
  endtask

  task automatic drive(int x);
    @(posedge clk); #1;
    data_valid = 1'b1;
    data = 16'(x);
    model_sample(x);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      data_valid = 1'b0;
      data = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    data_valid = 1'b0;
    data = '0;
    model_reset();
    #2;
    chk("rst_fir_valid", fir_valid, 0, 0);
    chk("rst_fir_d", fir_d, 0, 0);
    chk("rst_fft_valid", fft_valid, 0, 0);
    chk("rst_done", done, 0, 0);
    chk("rst_freq", freq, 0, 0);
    for (int k = 0; k < 16; k++) chk("rst_fft_d", fd[k], 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 300 && (fir_q.size() + re_q.size() + freq_q.size()) > 0; i++)
      @(posedge clk);
    idle(4);
    chk("drain_fir", fir_q.size(), 0, 0);
    chk("drain_fft", re_q.size(), 0, 0);
    chk("drain_freq", freq_q.size(), 0, 0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    int ef;
    real er, ei;
    cyc++;
    if (rst) begin
      if (fir_valid) begin
        ef = (fir_q.size() > 0) ? fir_q.pop_front() : 99999;
        chk("fir_d", $signed(fir_d), ef, 1);
      end
      if (fft_valid) begin
        fv_count++;
        if (spacing_on && last_fv > 0) chk("fft_spacing", cyc - last_fv, 16, 0);
        last_fv = cyc;
        for (int k = 0; k < 16; k++) begin
          er = (re_q.size() > 0) ? re_q.pop_front() : 1.0e6;
          ei = (im_q.size() > 0) ? im_q.pop_front() : 1.0e6;
          chk("fft_re", $signed(fd[k][31:16]), longint'(er), 3);
          chk("fft_im", $signed(fd[k][15:0]), longint'(ei), 3);
        end
      end
      if (done) begin
        chk("done_delay", cyc - last_fv, 2, 0);
        if (freq_q.size() > 0) chk("freq", freq, freq_q.pop_front(), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Impulse: window primed with zeros so outputs walk through C[0..31].
    exp_freq = -1;
    for (int i = 0; i < 31; i++) drive(0);
    drive(16'h0100);
    for (int i = 0; i < 31; i++) drive(0);
    drain();

    // DC 1.0: y = 0.75 -> X[0] = 16*192 = 3072, other bins 0, freq 0.
    do_reset();
    exp_freq = 0;
    for (int i = 0; i < 64; i++) drive(16'h0100);
    drain();

    // Cosine at bin 3, two phases: mirrored bins 3/13 tie, lowest wins.
    for (int p = 0; p < 2; p++) begin
      do_reset();
      exp_freq = 3;
      for (int n = 0; n < 95; n++)
        drive(int'(1024.0 * $cos(2.0 * PI * 3.0 * real'(n) / 16.0 + 0.6283 * real'(p))));
      drain();
    end

    // Same cosine with a 5-cycle data_valid gap mid-frame.
    do_reset();
    exp_freq = 3;
    for (int n = 0; n < 95; n++) begin
      if (n == 51) idle(5);
      drive(int'(1024.0 * $cos(2.0 * PI * 3.0 * real'(n) / 16.0)));
    end
    drain();

    // Reset at sample 40, then 32 fresh samples before the first output.
    do_reset();
    exp_freq = -1;
    for (int n = 0; n < 40; n++) drive(int'($urandom_range(1023)) - 512);
    do_reset();
    for (int n = 0; n < 40; n++) drive(int'($urandom_range(1023)) - 512);
    drain();

    // Long continuous run: 1024 FIR outputs -> 64 frames, 16 cycles apart.
    do_reset();
    exp_freq = -1;
    fv_count = 0;
    last_fv = -1000;
    spacing_on = 1'b1;
    for (int n = 0; n < 1055; n++)
      drive((n < 1024) ? int'($urandom_range(1023)) - 512 : 0);
    drain();
    spacing_on = 1'b0;
    chk("fft_frames", fv_count, 64, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fas.md
FAS -- requirements
Module: fas

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port data_valid, input, 1 bit: high marks data as a valid sample in that cycle.
REQ-004 SHALL have port data, input, 16 bits: signed Q8.8 input sample.
REQ-005 SHALL have port fir_valid, output, 1 bit: high marks fir_d as valid.
REQ-006 SHALL have port fir_d, output, 16 bits: signed Q8.8 FIR result.
REQ-007 SHALL have port fft_valid, output, 1 bit: one-cycle pulse marking a completed FFT frame.
REQ-008 SHALL have ports fft_d0..fft_d15, output, 32 bits each: bin k as {real[31:16], imag[15:0]}, each half signed Q8.8.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a completed peak analysis.
REQ-010 SHALL have port freq, output, 4 bits: index of the peak bin.

Function
REQ-011 SHALL implement a 32-tap FIR: y[n] = sum over k=0..31 of C[k]*x[n-k].
- C[k]: signed 20-bit Q4.16 constants FIR_C00..FIR_C31 from the team FIR coefficient include file.
REQ-012 SHALL shift one sample into the delay line on every clk edge where data_valid=1; the line holds zeros after reset.
REQ-013 SHALL assert fir_valid when the delay line holds 32 valid samples (first y for x[31]) and keep it high for every later valid sample.
- fir_d is updated in the same cycle as fir_valid.
- Fixed pipeline latency of at most 4 cycles.
REQ-014 SHALL reduce the full-precision FIR sum to Q8.8 by truncation; result within ±1 LSB of the exact value.
- On overflow, keep the low 16 bits (wrap; no saturation).
REQ-015 SHALL collect FIR outputs into frames of 16 consecutive results; frame m holds outputs 16m..16m+15, oldest first as x[0].
REQ-016 SHALL compute a 16-point DFT per frame: X[k] = sum over n of x[n]*W^(nk), W = e^(-j2π/16).
- Radix-2 or direct form allowed.
- Twiddle cos/sin magnitudes, Q1.16: 65536, 60547, 46340, 25079, 0.
REQ-017 SHALL present X[k] on fft_dk in natural (non-bit-reversed) order, each part within ±3 LSB of the exact Q8.8 result.
REQ-018 SHALL pulse fft_valid for exactly one cycle per frame.
- fft_d0..15 hold their values until the next fft_valid.
- Sustain one frame per 16 valid samples with no stalls.
REQ-019 SHALL, per frame, set freq to the k maximizing real²+imag² of X[k].
- On ties, choose the lowest k.
REQ-020 SHALL pulse done for one cycle exactly 2 cycles after each fft_valid.
- freq is valid in that cycle and held until the next done.
REQ-021 SHALL pause all progress (FIR shift, frame fill) while data_valid=0, resuming without loss.

Reset
REQ-022 SHALL, while rst=0, asynchronously clear:
- fir_valid, fft_valid, done;
- fir_d, fft_d0..15, freq;
- delay line, frame counter, all pipeline state.
REQ-023 SHALL, on reset asserted mid-frame, discard the partial frame; after release, restart at sample 0 and require 32 new samples before fir_valid.

Verification
REQ-024 Impulse: x[0]=0x0100 then zeros -> fir_d equals C[k] truncated to Q8.8 (±1) on successive outputs.
REQ-025 Constant input 0x0100 for 64 samples -> each frame X[0] = 16·Σ_k C[k] (Q8.8), all other bins 0 (±3); freq=0; done 2 cycles after fft_valid.
REQ-026 Input 1024 samples then zeros with data_valid held high -> exactly 64 fft_valid pulses from 1024 FIR outputs; fft_valid spacing 16 cycles.
REQ-027 Cosine at bin 3 fed through the FIR passband -> freq=3; same data phase-shifted -> freq still 3; a frame with equal peaks at bins 3 and 13 -> freq=3.
REQ-028 Toggle data_valid low for 5 cycles mid-frame -> outputs identical to the uninterrupted run, delayed 5 cycles.
REQ-029 Assert rst=0 at sample 40 -> all outputs 0 immediately; after release, fir_valid first rises 32 samples later.
